// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: format codes, opcodes and skid states for imm_gen_pipe (IMM_GEN_ZICSR_EN enables CSR zimm decode)
package imm_gen_pkg;
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
endpackage

// File: rtl/imm_gen_dec.sv
// imm_gen_dec: combinational RV immediate/format/illegal decode (IMM_GEN_ZICSR_EN adds CSR zimm)
module imm_gen_dec import imm_gen_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'b0};
  assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin imm = sx(i_imm); fmt = FMT_I; end
      OPC_STORE: begin imm = sx(s_imm); fmt = FMT_S; end
      OPC_BRANCH: begin imm = sx(b_imm); fmt = FMT_B; end
      OPC_JAL: begin imm = sx(j_imm); fmt = FMT_J; end
      OPC_LUI, OPC_AUIPC: begin imm = sx(u_imm); fmt = FMT_U; end
      OPC_OP, OPC_MISC_MEM: ;
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        imm = inst[14] ? XLEN'(inst[19:15]) : '0;
        fmt = inst[14] ? FMT_Z : FMT_NONE;
`endif
      end
      OPC_OPIMM32: begin
        imm = XLEN == 64 ? sx(i_imm) : '0;
        fmt = XLEN == 64 ? FMT_I : FMT_NONE;
        illegal = XLEN != 64;
      end
      OPC_OP32: illegal = XLEN != 64;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered valid/ready immediate generator with 2-entry skid and saturating counters (IMM_GEN_ZICSR_EN)
module imm_gen_pipe import imm_gen_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] inst_cnt_o,
  output logic [CNT_W-1:0] ill_cnt_o
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;
  skid_state_e state, state_d;
  entry_t head, skid, dec_e;
  logic rdy_q, acc, drn;
  logic [XLEN-1:0] dec_imm;
  logic [2:0] dec_fmt;
  logic dec_ill;
  imm_gen_dec #(.XLEN(XLEN)) u_dec (.inst(inst_i), .imm(dec_imm), .fmt(dec_fmt), .illegal(dec_ill));
  assign dec_e = {dec_imm, dec_fmt, dec_ill, tag_i};
  assign acc = in_valid_i & rdy_q;
  assign drn = out_valid_o & out_ready_i;
  assign in_ready_o = rdy_q;
  assign out_valid_o = state != EMPTY;
  assign {imm_o, fmt_o, illegal_o, tag_o} = head;
  always_comb
    state_d = state == EMPTY ? (acc ? ONE : EMPTY) :
              state == ONE   ? (acc & !drn ? TWO : !acc & drn ? EMPTY : ONE) :
                               (drn ? ONE : TWO);
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
      head <= '0;
      skid <= '0;
    end else begin
      state <= state_d;
      rdy_q <= state_d != TWO;
      if (state == TWO ? drn : acc & (state == EMPTY | drn)) head <= state == TWO ? skid : dec_e;
      if (state == ONE & acc & !drn) skid <= dec_e;
    end
  always_ff @(posedge clk_i)
    if (!rst_n_i || cnt_clr_i) begin
      inst_cnt_o <= '0;
      ill_cnt_o <= '0;
    end else if (drn) begin
      if (~&inst_cnt_o) inst_cnt_o <= inst_cnt_o + CNT_W'(1);
      if (head.ill && ~&ill_cnt_o) ill_cnt_o <= ill_cnt_o + CNT_W'(1);
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: randomized and directed check of imm_gen_pipe at XLEN 32 and 64 against a queue model
module tb_imm_gen_pipe;
  localparam int TAG_W = 5;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cnt_clr = 0;
  logic [31:0] inst = 0;
  logic [TAG_W-1:0] tag = 0;
  logic rdy32, rdy64, ov32, ov64, ill32, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0] fmt32, fmt64;
  logic [TAG_W-1:0] tag32, tag64;
  logic [15:0] ic32, lc32;
  logic [3:0] ic64, lc64;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [31:0] inst; logic [TAG_W-1:0] tag;} ent_t;
  ent_t q[$];
  int mc32 = 0, ml32 = 0, mc64 = 0, ml64 = 0;
  bit live = 0;
  logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37,
                           7'h17, 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B, 7'h7F};
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(16)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy32), .inst_i(inst),
    .tag_i(tag), .out_valid_o(ov32), .out_ready_i(out_ready), .imm_o(imm32), .fmt_o(fmt32),
    .illegal_o(ill32), .tag_o(tag32), .cnt_clr_i(cnt_clr), .inst_cnt_o(ic32), .ill_cnt_o(lc32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(4)) dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy64), .inst_i(inst),
    .tag_i(tag), .out_valid_o(ov64), .out_ready_i(out_ready), .imm_o(imm64), .fmt_o(fmt64),
    .illegal_o(ill64), .tag_o(tag64), .cnt_clr_i(cnt_clr), .inst_cnt_o(ic64), .ill_cnt_o(lc64));
  function automatic void ref_dec(input logic [31:0] in, input bit x64, output longint v, output int f, output bit il);
    longint u = longint'(in);
    longint sgn12 = in[31] ? 4096 : 0;
    v = 0;
    f = 0;
    il = 0;
    case (in[6:0])
      7'h03, 7'h13, 7'h67: begin v = (u >> 20) - sgn12; f = 1; end
      7'h23: begin v = (u >> 25) * 32 + ((u >> 7) & 31) - sgn12; f = 2; end
      7'h63: begin v = ((u >> 8) & 15) * 2 + ((u >> 25) & 63) * 32 + ((u >> 7) & 1) * 2048 - sgn12; f = 3; end
      7'h6F: begin
        v = ((u >> 21) & 1023) * 2 + ((u >> 20) & 1) * 2048 + ((u >> 12) & 255) * 4096 - (in[31] ? (longint'(1) << 20) : 0);
        f = 5;
      end
      7'h37, 7'h17: begin v = (u & 64'hFFFFF000) - (in[31] ? (longint'(1) << 32) : 0); f = 4; end
      7'h33, 7'h0F: ;
      7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
        if (in[14]) begin v = (u >> 15) & 31; f = 6; end
`endif
      end
      7'h1B: if (x64) begin v = (u >> 20) - sgn12; f = 1; end else il = 1;
      7'h3B: il = !x64;
      default: il = 1;
    endcase
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  task automatic step(input bit v, input logic [31:0] in, input logic [TAG_W-1:0] t, input bit r, input bit clr, input bit rn);
    longint e;
    int f;
    bit il, acc, drn;
    @(negedge clk);
    if (live) begin
      check("in_ready32", rdy32, q.size() < 2);
      check("in_ready64", rdy64, q.size() < 2);
      check("out_valid32", ov32, q.size() > 0);
      check("out_valid64", ov64, q.size() > 0);
      check("inst_cnt32", ic32, mc32);
      check("ill_cnt32", lc32, ml32);
      check("inst_cnt64", ic64, mc64);
      check("ill_cnt64", lc64, ml64);
      if (q.size() > 0) begin
        ref_dec(q[0].inst, 0, e, f, il);
        check("imm32", imm32, e[31:0]);
        check("fmt32", fmt32, f);
        check("illegal32", ill32, il);
        check("tag32", tag32, q[0].tag);
        ref_dec(q[0].inst, 1, e, f, il);
        check("imm64", imm64, e);
        check("fmt64", fmt64, f);
        check("illegal64", ill64, il);
        check("tag64", tag64, q[0].tag);
      end
    end
    in_valid = v;
    inst = in;
    tag = t;
    out_ready = r;
    cnt_clr = clr;
    rst_n = rn;
    if (!rn) begin
      q.delete();
      mc32 = 0; ml32 = 0; mc64 = 0; ml64 = 0;
      live = 1;
    end else if (live) begin
      acc = v && q.size() < 2;
      drn = r && q.size() > 0;
      if (drn) begin
        ref_dec(q[0].inst, 0, e, f, il);
        if (mc32 < 65535) mc32++;
        if (il && ml32 < 65535) ml32++;
        ref_dec(q[0].inst, 1, e, f, il);
        if (mc64 < 15) mc64++;
        if (il && ml64 < 15) ml64++;
        void'(q.pop_front());
      end
      if (clr) begin mc32 = 0; ml32 = 0; mc64 = 0; ml64 = 0; end
      if (acc) q.push_back('{in, t});
    end
  endtask
  task automatic settle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] ri;
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(1, 32'hFFF00093, 1, 0, 0, 1); settle();
    check("addi_imm32", imm32, 32'hFFFFFFFF);
    check("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    check("addi_fmt", fmt32, 1);
    check("addi_ill", ill32, 0);
    step(1, 32'hFE000EE3, 2, 1, 0, 1); settle();
    check("beq_imm32", imm32, 32'hFFFFFFFC);
    check("beq_fmt", fmt32, 3);
    step(1, 32'h0040006F, 3, 1, 0, 1); settle();
    check("jal_imm32", imm32, 32'h4);
    check("jal_fmt", fmt32, 5);
    step(1, 32'h800000B7, 4, 1, 0, 1); settle();
    check("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    check("lui_imm32", imm32, 32'h80000000);
    check("lui_fmt64", fmt64, 4);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    step(1, 32'h0000007F, 5, 1, 0, 1);
    step(1, 32'h0000007F, 6, 1, 0, 1);
    step(1, 32'hFFF00093, 7, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1); settle();
    check("cnt3_inst32", ic32, 3);
    check("cnt3_ill32", lc32, 2);
    check("cnt3_inst64", ic64, 3);
    check("cnt3_ill64", lc64, 2);
    step(1, 32'hFFF00093, 8, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1); settle();
    check("clr_inst32", ic32, 0);
    check("clr_ill32", lc32, 0);
    step(1, 32'h00000013, 1, 0, 0, 1);
    step(1, 32'h00000013, 2, 0, 0, 1);
    step(1, 32'h00000013, 3, 0, 0, 1); settle();
    check("stall_rdy32", rdy32, 0);
    check("stall_rdy64", rdy64, 0);
    check("stall_tag", tag32, 1);
    step(1, 32'h00000013, 3, 1, 0, 1); settle();
    check("release_tag2", tag32, 2);
    step(1, 32'h00000013, 3, 1, 0, 1); settle();
    check("release_tag3", tag32, 3);
    step(0, 0, 0, 1, 0, 1);
    step(1, 32'hFFF00093, 9, 0, 0, 1);
    step(1, 32'hFFF00093, 10, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0); settle();
    check("rst_valid", ov32, 0);
    check("rst_ready", rdy32, 1);
    check("rst_cnt32", ic32, 0);
    check("rst_cnt64", ic64, 0);
    step(1, 32'h3401D073, 11, 0, 0, 1); settle();
`ifdef IMM_GEN_ZICSR_EN
    check("csr_imm32", imm32, 3);
    check("csr_fmt", fmt32, 6);
`else
    check("csr_imm32", imm32, 0);
    check("csr_fmt", fmt32, 0);
`endif
    check("csr_ill", ill32, 0);
    step(0, 0, 0, 1, 0, 1);
    repeat (800) begin
      ri = $urandom;
      if ($urandom % 4 != 0) ri[6:0] = ops[$urandom % 14];
      step($urandom % 4 != 0, ri, TAG_W'($urandom), $urandom % 3 != 0,
           $urandom % 120 == 0, $urandom % 200 != 0);
    end
    repeat (3) step(0, 0, 0, 1, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
